// File: rtl/hrange_sum_caller.sv
`timescale 1ns/1ps
// Caller for an hrange-style generator: launches it, folds the yielded stream
// into (sum, count), and offers that pair upstream as a single-shot generator result.
module hrange_sum_caller #(
  parameter int WIDTH = 32
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] step,
  input  logic             _ready,
  output logic             _valid,
  output logic             _done,
  output logic [WIDTH-1:0] _0,
  output logic [WIDTH-1:0] _1,
  output logic             gen_start,
  output logic [WIDTH-1:0] gen_base,
  output logic [WIDTH-1:0] gen_limit,
  output logic [WIDTH-1:0] gen_step,
  output logic             gen_ready,
  input  logic             gen_valid,
  input  logic             gen_done,
  input  logic [WIDTH-1:0] gen_0
);

  typedef enum logic [1:0] {IDLE, LAUNCH, COLLECT, EMIT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sum, cnt;
  logic [WIDTH-1:0] sum_nxt, cnt_nxt;

  // Running totals including a value accepted on the current edge, so a
  // final value coinciding with gen_done is still folded into the result.
  assign sum_nxt = sum + (gen_valid ? gen_0 : '0);
  assign cnt_nxt = cnt + {{(WIDTH-1){1'b0}}, gen_valid};

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state     <= IDLE;
      sum       <= '0;
      cnt       <= '0;
      _valid    <= 1'b0;
      _done     <= 1'b0;
      _0        <= '0;
      _1        <= '0;
      gen_start <= 1'b0;
      gen_ready <= 1'b0;
      gen_base  <= '0;
      gen_limit <= '0;
      gen_step  <= '0;
    end else begin
      _done <= 1'b0;
      if (_start) begin
        // Restart from any state; a pending result is abandoned.
        gen_base  <= base;
        gen_limit <= limit;
        gen_step  <= step;
        sum       <= '0;
        cnt       <= '0;
        _valid    <= 1'b0;
        gen_start <= 1'b1;
        gen_ready <= 1'b1;
        state     <= LAUNCH;
      end else begin
        case (state)
          IDLE: ;
          LAUNCH: begin
            // gen_ready stays high here so stale output from an aborted run drains.
            gen_start <= 1'b0;
            state     <= COLLECT;
          end
          COLLECT: begin
            if (gen_valid) begin
              sum <= sum_nxt;
              cnt <= cnt_nxt;
            end
            if (gen_done) begin
              _0        <= sum_nxt;
              _1        <= cnt_nxt;
              _valid    <= 1'b1;
              gen_ready <= 1'b0;
              state     <= EMIT;
            end
          end
          EMIT: begin
            if (_ready) begin
              _valid <= 1'b0;
              _done  <= 1'b1;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
